// File: rtl/frame_max_pkg.sv
// Shared types and defaults for the frame_max streaming reduction stage.
package frame_max_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/frame_max_max2.sv
// Two-input unsigned max comparator; purely combinational.
module max2 #(
    parameter int WIDTH = frame_max_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out
);

    assign out = (a > b) ? a : b;

endmodule

// File: rtl/frame_max.sv
// Streaming frame maximum: reduces up to FRAME_LEN samples per frame and
// presents the maximum and the sample count on a valid/ready result port.
module frame_max
    import frame_max_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FRAME_LEN = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_max,
    output logic [$clog2(FRAME_LEN+1)-1:0]   out_count
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; ready/valid here depend on state only, never on inputs.
    state_t            state, state_nxt;
    logic [WIDTH-1:0]  max_r;
    logic [WIDTH-1:0]  max_new;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              accept;
    logic              frame_done;

    max2 #(.WIDTH(WIDTH)) u_max2 (
        .a   (max_r),
        .b   (in_data),
        .out (max_new)
    );

    assign in_ready   = (state != HOLD);
    assign out_valid  = (state == HOLD);
    assign out_max    = max_r;
    assign out_count  = cnt;
    assign accept     = in_valid & in_ready;
    // In IDLE cnt is 0, so cnt_inc==FRAME_LEN also covers FRAME_LEN==1.
    assign cnt_inc    = cnt + CNT_W'(1);
    assign frame_done = in_last | (cnt_inc == CNT_W'(FRAME_LEN));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) state_nxt = frame_done ? HOLD : ACCUM;
            end
            HOLD: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            max_r <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        max_r <= in_data;
                        cnt   <= CNT_W'(1);
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        max_r <= max_new;
                        cnt   <= cnt_inc;
                    end
                end
                HOLD: begin
                    // max_r is kept after the transfer; only the count clears.
                    if (out_ready) cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_max.sv
// Directed self-checking bench for frame_max with a result scoreboard.
module tb_frame_max;

    localparam int WIDTH     = 16;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [CNT_W-1:0] out_count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_max_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];

    // reference model of the frame being built
    logic [WIDTH-1:0] m_max;
    int               m_cnt;

    frame_max #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        failures++;
        $error("FAIL %s", tag);
    endtask

    // result monitor: pops the scoreboard on each output transfer
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_max_q.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                check("out_max", 32'(out_max), 32'(exp_max_q.pop_front()));
                check("out_count", 32'(out_count), 32'(exp_cnt_q.pop_front()));
            end
        end
    end

    // drive one sample; returns just after the edge that accepted it
    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        int budget;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        budget   = 50;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        if (!in_ready) begin
            fail_now("send_timeout");
        end else begin
            @(posedge clk);
            if (m_cnt == 0 || d > m_max) m_max = d;
            m_cnt++;
            if (last || m_cnt == FRAME_LEN) begin
                exp_max_q.push_back(m_max);
                exp_cnt_q.push_back(CNT_W'(m_cnt));
                m_cnt = 0;
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 30;
        while (exp_max_q.size() != 0 && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        if (exp_max_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        m_max     = '0;
        m_cnt     = 0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_max", 32'(out_max), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // back-to-back full frame, single-cycle result
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd5,  1'b0);
        send(16'd20, 1'b0);
        @(negedge clk);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("pulse_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        wait_drain();

        // early close on in_last, then single-sample frame
        send(16'd40, 1'b0);
        send(16'd30, 1'b1);
        wait_drain();
        send(16'd7, 1'b1);
        wait_drain();

        // unsigned boundary values
        send(16'h0000, 1'b0);
        send(16'hFFFF, 1'b0);
        send(16'h8000, 1'b0);
        send(16'h0001, 1'b0);
        wait_drain();

        // backpressure while a result is pending
        out_ready = 1'b0;
        send(16'd11, 1'b0);
        send(16'd12, 1'b0);
        send(16'd14, 1'b0);
        send(16'd13, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'd99;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_max", 32'(out_max), 32'd14);
            check("bp_out_count", 32'(out_count), 32'd4);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'd99, 1'b1);
        wait_drain();

        // gapped input
        send(16'd3, 1'b0);
        @(posedge clk); #1;
        send(16'd9, 1'b0);
        @(posedge clk); #1;
        send(16'd1, 1'b0);
        @(posedge clk); #1;
        send(16'd2, 1'b0);
        wait_drain();

        // reset mid-frame discards the partial result
        send(16'd50, 1'b0);
        send(16'd60, 1'b0);
        rst   = 1'b1;
        m_cnt = 0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_out_valid", 32'(out_valid), 32'd0);
            check("postrst_in_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        wait_drain();

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_max_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_max.md
Name: frame_max

Overview:
- Streaming reduction stage that sits upstream of the two-input max comparator.
- Accepts a stream of unsigned samples over a valid/ready handshake.
- On each accepted sample, feeds the comparator the running maximum and the new sample, and registers the result.
- At frame end, presents the frame maximum and the sample count on a valid/ready output port.

Parameters:
- WIDTH, 16, sample and result width in bits.
- FRAME_LEN, 8, maximum samples per frame (>=1); a frame also closes early on in_last.
- CNT_W, $clog2(FRAME_LEN+1), width of the count output (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  WIDTH  sample, unsigned.
- in_last  input  1  qualifies in_data as the final sample of the frame; ignored unless in_valid & in_ready.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_max  output  WIDTH  maximum of the frame's samples.
- out_count  output  CNT_W  number of samples in the frame (1..FRAME_LEN).

Behaviour:
- Reset, asynchronous on rst high:
  - state=IDLE, max_r=0, cnt=0.
  - out_valid=0, in_ready=1 once rst deasserts.
  - out_max=0, out_count=0.
- Accept: in_valid & in_ready at a rising edge. The transfer condition on the output side is out_valid & out_ready.
- State IDLE: in_ready=1, out_valid=0. On accept:
  - max_r<=in_data, cnt<=1.
  - Go to HOLD if in_last or FRAME_LEN==1; otherwise go to ACCUM.
- State ACCUM: in_ready=1, out_valid=0. On accept:
  - max_r<=max2(max_r,in_data), cnt<=cnt+1.
  - Go to HOLD if in_last or cnt+1==FRAME_LEN.
  - Without accept, hold all state (gaps in in_valid are allowed).
- State HOLD: in_ready=0, out_valid=1, out_max=max_r, out_count=cnt.
  - On out_ready go to IDLE, clear cnt to 0, keep max_r.
  - While out_ready is low, out_max and out_count stay stable and in_valid is ignored.
- Latency: out_valid rises on the edge that accepts the last sample, i.e. it is visible the cycle after that sample is presented.
- No overlap: a new frame's first sample cannot be taken in the same cycle as the output transfer. Minimum period is N+1 cycles for an N-sample frame.
- Compare rule: unsigned. On equal values max_r is unchanged (both choices give the same value).
- cnt never exceeds FRAME_LEN. in_last on the FRAME_LEN-th sample closes the frame exactly once.
- Reset mid-frame or during HOLD: partial or pending result is discarded and no out_valid pulse is produced.
- in_ready and out_valid are decoded from state only; there is no combinational path from any input.

Decomposition:
- Shared package frame_max_pkg:
  - state enum {IDLE, ACCUM, HOLD}.
  - Default WIDTH constant (16).
- One sub-module, max2:
  - Purely combinational; out = (a>b) ? a : b over WIDTH bits.
  - Instantiated once, with operands max_r and in_data.

Test Plan:
- FRAME_LEN=4, back-to-back 10,20,5,20 with out_ready=1 -> out_valid for 1 cycle after the 4th accept, out_max=20, out_count=4, in_ready=0 that cycle.
- Samples 40 then 30 with in_last on 30 -> out_max=40, out_count=2; next frame 7 alone with in_last -> out_max=7, out_count=1.
- Boundary values 0x0000, 0xFFFF, 0x8000, 0x0001 with FRAME_LEN=4 -> out_max=0xFFFF (unsigned, not signed).
- Backpressure: result pending, out_ready low 5 cycles while in_valid=1 with data 99 -> out_valid held, out_max/out_count constant, in_ready=0, 99 not absorbed. Raise out_ready -> IDLE; 99 is accepted as the next frame's first sample.
- Gapped input: in_valid toggled every other cycle with 3,9,1,2 -> out_max=9, out_count=4, identical to back-to-back.
- Reset mid-frame: rst pulse after 2 of 4 samples (50,60) -> out_valid stays 0. Then 1,2,3,4 -> out_max=4, out_count=4 (60 does not leak).
